// File: rtl/multi_hole_score_fsm.sv
// Whac-a-mole round scorer: multi-hole evaluation, saturating score, hit/miss streaks, difficulty level.
// Latency: outputs update one edge after the timeUp rising edge is sampled; pulses last one cycle.
// Backpressure: none; enable low forces OFF and holds score/level/streaks.
module multi_hole_score_fsm #(
    parameter int N          = 4,
    parameter int SCORE_W    = 10,
    parameter int STREAK_LEN = 4,
    parameter int MISS_LEN   = 2,
    parameter int LEVEL_W    = 3,
    parameter int MAX_LEVEL  = 7
) (
    input  logic               systemClock,
    input  logic               reset,
    input  logic               enable,
    input  logic               timeUp,
    input  logic [N-1:0]       active,
    input  logic [N-1:0]       hit,
    output logic [1:0]         add,
    output logic               shrink,
    output logic               grow,
    output logic [SCORE_W-1:0] score,
    output logic [LEVEL_W-1:0] level,
    output logic [2:0]         current
);

    // Streak counters must be able to hold the larger of the two target lengths.
    localparam int STREAK_MAX = (STREAK_LEN > MISS_LEN) ? STREAK_LEN : MISS_LEN;
    localparam int CNT_W      = $clog2(STREAK_MAX + 1);
    localparam int PC_W       = $clog2(N + 1);

    localparam logic [1:0]         ADD_MISS  = 2'd0;
    localparam logic [1:0]         ADD_HIT   = 2'd1;
    localparam logic [1:0]         ADD_NONE  = 2'd2;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [LEVEL_W-1:0] LEVEL_TOP = LEVEL_W'(MAX_LEVEL);
    localparam logic [CNT_W-1:0]   HIT_TGT   = CNT_W'(STREAK_LEN);
    localparam logic [CNT_W-1:0]   MISS_TGT  = CNT_W'(MISS_LEN);

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_LOW  = 3'd2,
        ST_WAIT_HIGH = 3'd3,
        ST_EVAL      = 3'd4
    } state_t;

    state_t             state_q;
    logic [1:0]         add_q;
    logic               shrink_q;
    logic               grow_q;
    logic [SCORE_W-1:0] score_q;
    logic [LEVEL_W-1:0] level_q;
    logic [CNT_W-1:0]   hit_cnt_q;
    logic [CNT_W-1:0]   miss_cnt_q;
    logic [N-1:0]       hm_q;
    logic [N-1:0]       mm_q;

    logic [PC_W-1:0]    hm_pop_d;
    logic [SCORE_W:0]   score_sum_d;
    logic [SCORE_W-1:0] score_d;
    logic [CNT_W-1:0]   hit_inc_d;
    logic [CNT_W-1:0]   miss_inc_d;

    // Round arithmetic: popcount of captured hits, clamped score sum, streak increments.
    always_comb begin
        hm_pop_d = '0;
        for (int i = 0; i < N; i++) begin
            hm_pop_d = hm_pop_d + PC_W'(hm_q[i]);
        end
        score_sum_d = {1'b0, score_q} + (SCORE_W + 1)'(hm_pop_d);
        score_d     = score_sum_d[SCORE_W] ? SCORE_MAX : score_sum_d[SCORE_W-1:0];
        hit_inc_d   = hit_cnt_q + CNT_W'(1);
        miss_inc_d  = miss_cnt_q + CNT_W'(1);
    end

    // Round FSM with registered result pulses, score, level and streak counters.
    always_ff @(posedge systemClock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_OFF;
            add_q      <= ADD_NONE;
            shrink_q   <= 1'b0;
            grow_q     <= 1'b0;
            score_q    <= '0;
            level_q    <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            hm_q       <= '0;
            mm_q       <= '0;
        end else begin
            // Pulses are idle unless an evaluated round sets them below.
            add_q    <= ADD_NONE;
            shrink_q <= 1'b0;
            grow_q   <= 1'b0;
            if (!enable) begin
                // Disable wins over everything, including a pending EVAL.
                state_q <= ST_OFF;
            end else begin
                unique case (state_q)
                    ST_OFF: begin
                        state_q <= ST_START;
                    end
                    ST_START: begin
                        hit_cnt_q  <= '0;
                        miss_cnt_q <= '0;
                        state_q    <= ST_WAIT_LOW;
                    end
                    ST_WAIT_LOW: begin
                        // Arm only after timeUp is seen low, so a held level counts once.
                        if (!timeUp) begin
                            state_q <= ST_WAIT_HIGH;
                        end
                    end
                    ST_WAIT_HIGH: begin
                        if (timeUp) begin
                            hm_q    <= active & hit;
                            mm_q    <= active & ~hit;
                            state_q <= ST_EVAL;
                        end
                    end
                    ST_EVAL: begin
                        state_q <= ST_WAIT_LOW;
                        // Partial credit: hits score even in a MISS round.
                        score_q <= score_d;
                        if (mm_q != '0) begin
                            add_q     <= ADD_MISS;
                            hit_cnt_q <= '0;
                            if (miss_inc_d == MISS_TGT) begin
                                miss_cnt_q <= '0;
                                if (level_q != '0) begin
                                    level_q <= level_q - LEVEL_W'(1);
                                    grow_q  <= 1'b1;
                                end
                            end else begin
                                miss_cnt_q <= miss_inc_d;
                            end
                        end else if (hm_q != '0) begin
                            add_q      <= ADD_HIT;
                            miss_cnt_q <= '0;
                            if (hit_inc_d == HIT_TGT) begin
                                hit_cnt_q <= '0;
                                if (level_q < LEVEL_TOP) begin
                                    level_q  <= level_q + LEVEL_W'(1);
                                    shrink_q <= 1'b1;
                                end
                            end else begin
                                hit_cnt_q <= hit_inc_d;
                            end
                        end
                        // No mole up at all: idle round, streaks untouched.
                    end
                    default: begin
                        state_q <= ST_OFF;
                    end
                endcase
            end
        end
    end

    assign add     = add_q;
    assign shrink  = shrink_q;
    assign grow    = grow_q;
    assign score   = score_q;
    assign level   = level_q;
    assign current = state_q;

endmodule

// File: tb/tb_multi_hole_score_fsm.sv
// Directed bench for multi_hole_score_fsm: default instance plus a SCORE_W=4 instance on shared stimulus.
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
// Expected values are hand-computed constants per scenario.
module tb_multi_hole_score_fsm;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       time_up;
    logic [3:0] active;
    logic [3:0] hit;

    logic [1:0] add;
    logic       shrink;
    logic       grow;
    logic [9:0] score;
    logic [2:0] level;
    logic [2:0] current;

    logic [1:0] add2;
    logic       shrink2;
    logic       grow2;
    logic [3:0] score2;
    logic [2:0] level2;
    logic [2:0] current2;

    int checks;
    int errors;

    // Values captured by run_round at E+1 and E+2.
    logic [1:0] r_add;
    logic       r_shrink;
    logic       r_grow;
    logic [9:0] r_score;
    logic [2:0] r_level;
    logic [3:0] r_score2;
    logic [1:0] r_add_post;
    logic       r_pulse_post;
    logic [2:0] r_cur_e;

    multi_hole_score_fsm dut (
        .systemClock(clk), .reset(rst_n), .enable(enable), .timeUp(time_up),
        .active(active), .hit(hit), .add(add), .shrink(shrink), .grow(grow),
        .score(score), .level(level), .current(current)
    );

    multi_hole_score_fsm #(.SCORE_W(4)) dut_sat (
        .systemClock(clk), .reset(rst_n), .enable(enable), .timeUp(time_up),
        .active(active), .hit(hit), .add(add2), .shrink(shrink2), .grow(grow2),
        .score(score2), .level(level2), .current(current2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts in WAIT_HIGH with timeUp low; leaves in WAIT_HIGH with timeUp low.
    task automatic run_round(input logic [3:0] a, input logic [3:0] h);
        active  = a;
        hit     = h;
        time_up = 1'b1;
        step();                       // edge E
        r_cur_e = current;
        time_up = 1'b0;
        step();                       // edge E+1
        r_add    = add;
        r_shrink = shrink;
        r_grow   = grow;
        r_score  = score;
        r_level  = level;
        r_score2 = score2;
        step();                       // edge E+2
        r_add_post   = add;
        r_pulse_post = shrink | grow;
    endtask

    int shrink_cnt;
    int eval_cnt;

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        enable  = 1'b0;
        time_up = 1'b0;
        active  = '0;
        hit     = '0;
        #12;
        check("rst_add", add, 2);
        check("rst_shrink", shrink, 0);
        check("rst_grow", grow, 0);
        check("rst_score", score, 0);
        check("rst_level", level, 0);
        check("rst_current", current, 0);

        rst_n = 1'b1;
        step();
        check("off_hold", current, 0);
        enable = 1'b1;
        step();
        check("start", current, 1);
        step();
        check("wait_low", current, 2);
        step();
        check("wait_high", current, 3);

        // Basic hit round.
        run_round(4'b0011, 4'b0011);
        check("basic_cur_eval", r_cur_e, 4);
        check("basic_add", r_add, 1);
        check("basic_score", r_score, 2);
        check("basic_add_post", r_add_post, 2);

        // Rounds 2..4 of the first streak; 4th levels up.
        run_round(4'b1111, 4'b1111);
        run_round(4'b1111, 4'b1111);
        check("streak3_shrink", r_shrink, 0);
        run_round(4'b1111, 4'b1111);
        check("lvlup_shrink", r_shrink, 1);
        check("lvlup_level", r_level, 1);
        check("lvlup_score", r_score, 14);
        check("lvlup_pulse_post", r_pulse_post, 0);

        // Climb to level 7: six more streaks.
        shrink_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            run_round(4'b1111, 4'b1111);
            if (r_shrink) shrink_cnt++;
        end
        check("climb_shrinks", shrink_cnt, 6);
        check("climb_level", r_level, 7);
        check("climb_score", r_score, 110);
        check("sat_score", r_score2, 15);

        // Ceiling: a full streak at level 7 gives no pulse.
        for (int i = 0; i < 4; i++) run_round(4'b1111, 4'b1111);
        check("ceil_shrink", r_shrink, 0);
        check("ceil_level", r_level, 7);
        check("ceil_score", r_score, 126);
        check("sat_hold", r_score2, 15);

        // Partial-credit misses down to level 2.
        for (int i = 0; i < 10; i++) run_round(4'b1111, 4'b0101);
        check("down_level", r_level, 2);
        run_round(4'b1111, 4'b0101);
        check("miss1_add", r_add, 0);
        check("miss1_grow", r_grow, 0);
        check("miss1_score", r_score, 148);
        run_round(4'b1111, 4'b0101);
        check("miss2_add", r_add, 0);
        check("miss2_grow", r_grow, 1);
        check("miss2_level", r_level, 1);
        check("miss2_score", r_score, 150);
        run_round(4'b1111, 4'b0101);
        run_round(4'b1111, 4'b0101);
        check("to_zero_level", r_level, 0);
        run_round(4'b1111, 4'b0101);
        run_round(4'b1111, 4'b0101);
        check("floor_grow", r_grow, 0);
        check("floor_level", r_level, 0);
        check("floor_score", r_score, 158);

        // Idle round between hits must not break the hit streak.
        for (int i = 0; i < 3; i++) run_round(4'b1111, 4'b1111);
        check("pre_idle_score", r_score, 170);
        run_round(4'b0000, 4'b1111);
        check("idle_add", r_add, 2);
        check("idle_score", r_score, 170);
        check("idle_level", r_level, 0);
        run_round(4'b1111, 4'b1111);
        check("post_idle_shrink", r_shrink, 1);
        check("post_idle_level", r_level, 1);

        // timeUp held high for 20 cycles: exactly one evaluation.
        eval_cnt = 0;
        active   = 4'b1111;
        hit      = 4'b1111;
        time_up  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (current == 3'd4) eval_cnt++;
        end
        check("held_evals", eval_cnt, 1);
        check("held_score", score, 178);
        time_up = 1'b0;
        step();
        step();
        check("held_rearm", current, 3);

        // Enable dropped while in EVAL: round discarded.
        time_up = 1'b1;
        step();
        check("drop_in_eval", current, 4);
        enable  = 1'b0;
        time_up = 1'b0;
        step();
        check("drop_current", current, 0);
        check("drop_add", add, 2);
        check("drop_shrink", shrink, 0);
        check("drop_score", score, 178);
        check("drop_level", level, 1);

        // Async reset between edges.
        enable = 1'b1;
        step();
        step();
        step();
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_score", score, 0);
        check("arst_level", level, 0);
        check("arst_current", current, 0);
        check("arst_add", add, 2);
        check("arst_score2", score2, 0);
        #2;
        rst_n = 1'b1;
        step();
        check("post_rst_start", current, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_hole_score_fsm.md
# multi_hole_score_fsm

Parametrised next-generation score/difficulty controller for the whac-a-mole game. It evaluates N holes per round instead of a single hit flag, and accumulates a saturating score. It also tracks hit and miss streaks with configurable lengths and maintains a difficulty level. It sits between the per-hole hit latches and the round timer, and its `shrink`/`grow` pulses drive the timer's window-length control.

## Interface
- `N`, 4: number of holes evaluated per round (1..16).
- `SCORE_W`, 10: score width; score saturates at 2^SCORE_W-1.
- `STREAK_LEN`, 4: consecutive HIT rounds needed for one level-up (>=1).
- `MISS_LEN`, 2: consecutive MISS rounds needed for one level-down (>=1).
- `LEVEL_W`, 3: level width.
- `MAX_LEVEL`, 7: level ceiling (<= 2^LEVEL_W-1).

- `systemClock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `enable`  in  1  game running; low forces OFF.
- `timeUp`  in  1  round timer; each 0->1 transition ends one round.
- `active`  in  N  holes that had a mole up this round; stable while timeUp is 1.
- `hit`  in  N  sticky per-hole hit flags from the hit latches; stable while timeUp is 1.
- `add`  out  2  round-result pulse: 2 = none, 1 = HIT round, 0 = MISS round.
- `shrink`  out  1  one-cycle pulse: level increased, so the window shrinks.
- `grow`  out  1  one-cycle pulse: level decreased, so the window grows.
- `score`  out  SCORE_W  accumulated score.
- `level`  out  LEVEL_W  current difficulty level.
- `current`  out  3  FSM state: OFF=0, START=1, WAIT_LOW=2, WAIT_HIGH=3, EVAL=4.

## Operation
- **OFF**
  - Stays here while `enable`=0.
  - `enable`=1 -> START.
- **START** (one cycle)
  - Clears the hit and miss streak counters.
  - Does not clear `score` or `level`.
  - Next state WAIT_LOW.
- **WAIT_LOW**
  - Waits for `timeUp`=0.
  - This arming step prevents a timeUp level that is still high from being counted twice.
  - On `timeUp`=0 -> WAIT_HIGH.
- **WAIT_HIGH**
  - Waits for `timeUp`=1.
  - On that edge, registers `hm = active & hit` and `mm = active & ~hit`, then -> EVAL.
- **EVAL** (one cycle)
  - Classifies the round, updates counters and pulses, then -> WAIT_LOW.
  - MISS if `mm` != 0.
  - HIT if `mm` == 0 and `hm` != 0.
  - IDLE if `active` == 0.
- **`enable`=0 in any state** -> OFF on the next edge.
  - Pulses are forced idle (`add`=2, `shrink`=`grow`=0).
  - `score`, `level` and the streak counters are held.
- **Score**
  - `score += popcount(hm)` in every evaluated round, including MISS rounds (partial credit).
  - Sum is computed at SCORE_W+1 bits and clamped to 2^SCORE_W-1.
- **HIT round**
  - `add`=1; miss streak cleared; hit streak incremented.
  - When the hit streak reaches STREAK_LEN, the streak is cleared.
  - At that point, if `level` < MAX_LEVEL: `level`+1 and `shrink`=1.
  - If `level` = MAX_LEVEL: no pulse and the level is held.
- **MISS round**
  - `add`=0; hit streak cleared; miss streak incremented.
  - When the miss streak reaches MISS_LEN, the streak is cleared.
  - At that point, if `level` > 0: `level`-1 and `grow`=1. At level 0: no pulse.
- **IDLE round**
  - `add` stays 2; no streak, score or level change.
- `shrink` and `grow` are never high together.
- Streak counters are ceil(log2(max(STREAK_LEN, MISS_LEN)+1)) bits wide.

## Timing
- All outputs are registered.
- Reset values: `add`=2, `shrink`=0, `grow`=0, `score`=0, `level`=0, `current`=OFF (0), streaks 0.
- Round latency:
  - Edge E: `timeUp`=1 first sampled in WAIT_HIGH; `hm`/`mm` captured; `current` becomes EVAL.
  - Edge E+1: `add`, `shrink`, `grow`, `score`, `level` update; `current` becomes WAIT_LOW.
  - Edge E+2: pulses return to idle.
- `timeUp` held high for many cycles produces exactly one evaluation.
- `timeUp` must return to 0 for at least one cycle (seen in WAIT_LOW) before the next round.
- `enable` falling edge during EVAL: OFF wins, and that round's result is discarded.
- `reset` asserted mid-round clears state asynchronously; after release the FSM starts in OFF.
- Minimum round period: 3 cycles (one cycle with `timeUp`=0, then 0->1, then EVAL).

## Test plan
- **Basic hit round.** `reset`, `enable`=1, `active`=4'b0011, `hit`=4'b0011, one `timeUp` pulse.
  - At E+1: `add`=1, `score`=2. At E+2: `add`=2.
- **Level-up and ceiling.** Four consecutive full-hit rounds.
  - The 4th round gives `shrink`=1 for one cycle and `level`=1.
  - Repeat at `level`=7: no shrink pulse, `level` stays 7.
- **Partial-credit miss and level-down.** From `level`=2: `active`=4'b1111 with `hit`=4'b0101, twice.
  - Each round: `add`=0 and `score` +2.
  - The 2nd round gives `grow`=1 and `level`=1.
  - At `level`=0: no grow pulse.
- **IDLE round and held timeUp.** `active`=0 round -> `add` stays 2, no counter changes.
  - Then `timeUp` held high for 20 cycles -> exactly one evaluation.
- **Score saturation.** SCORE_W=4, repeated 4-hit rounds -> `score` sticks at 15.
- **Enable drop and async reset.** Drop `enable` while in EVAL -> `current`=OFF, no pulse, `score` held.
  - Assert `reset` between clock edges -> all outputs take their reset values immediately.
